// File: rtl/hack_rom_loader_pkg.sv
// Shared definitions for the Hack ROM loader: loader states and ROM geometry.
package hack_pkg;

    localparam int unsigned ROM_ADDR_W = 15;

    // Largest image, in words, that fits a ROM with the given address width.
    function automatic int unsigned max_words(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    localparam int unsigned MAX_WORDS = max_words(ROM_ADDR_W);

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DAT_HI,
        DAT_LO,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/hack_rom_loader_timeout_counter.sv
// Idle-cycle counter: flags expiry on the TIMEOUT-th consecutive enabled cycle.
module timeout_counter #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned   CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Count idle cycles while enabled; restart from zero on clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign expired = enable && (r_count == LAST);

endmodule

// File: rtl/hack_rom_loader.sv
// Byte-stream loader for the Hack instruction ROM; holds the CPU in reset while loading.
module hack_rom_loader
    import hack_pkg::*;
#(
    parameter int unsigned ADDR_W  = ROM_ADDR_W,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned MAX_N = max_words(ADDR_W);

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_hi;
    logic [15:0]       r_remain;
    logic              r_rom_we;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [15:0]       r_rom_data;

    logic              w_accept;
    logic              w_start_ok;
    logic              w_expired;
    logic [15:0]       w_count;

    assign w_accept   = in_valid && in_ready;
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == ERR));
    assign w_count    = {r_hi, in_data};

    timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_accept || w_start_ok),
        .enable  (in_ready),
        .expired (w_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; an accept in the same cycle as expiry takes priority.
    // After the last low byte the FSM stays in DAT_LO (not ready) for the
    // rom_we cycle, so DONE lands one cycle after the final write.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, ERR: begin
                if (start) w_next = CNT_HI;
            end
            CNT_HI: begin
                if (w_accept)       w_next = CNT_LO;
                else if (w_expired) w_next = ERR;
            end
            CNT_LO: begin
                if (w_accept) begin
                    if (w_count == '0)             w_next = DONE;
                    else if (32'(w_count) > MAX_N) w_next = ERR;
                    else                           w_next = DAT_HI;
                end else if (w_expired) begin
                    w_next = ERR;
                end
            end
            DAT_HI: begin
                if (w_accept)       w_next = DAT_LO;
                else if (w_expired) w_next = ERR;
            end
            DAT_LO: begin
                if (r_remain == '0)  w_next = DONE;
                else if (w_accept)   w_next = (r_remain == 16'd1) ? DAT_LO : DAT_HI;
                else if (w_expired)  w_next = ERR;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (r_state)
            CNT_HI, CNT_LO, DAT_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DAT_LO: begin
                in_ready = (r_remain != '0);
                busy     = 1'b1;
            end
            DONE:    done  = 1'b1;
            ERR:     error = 1'b1;
            default: ;
        endcase
        cpu_hold = busy || error;
    end

    // Byte packing, word counting and the registered ROM write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi       <= '0;
            r_remain   <= '0;
            r_rom_we   <= 1'b0;
            r_rom_addr <= '0;
            r_rom_data <= '0;
        end else begin
            r_rom_we <= 1'b0;
            if (w_accept && ((r_state == CNT_HI) || (r_state == DAT_HI))) begin
                r_hi <= in_data;
            end
            if (w_accept && (r_state == CNT_LO)) begin
                r_remain <= w_count;
            end
            if (w_accept && (r_state == DAT_LO)) begin
                r_remain   <= r_remain - 16'd1;
                r_rom_we   <= 1'b1;
                r_rom_data <= w_count;
            end
            if (w_start_ok) begin
                r_rom_addr <= '0;
            end else if (r_rom_we) begin
                r_rom_addr <= r_rom_addr + ADDR_W'(1);
            end
        end
    end

    assign rom_we   = r_rom_we;
    assign rom_addr = r_rom_addr;
    assign rom_data = r_rom_data;

endmodule
